// File: rtl/mem_if_pkg.sv
// Shared definitions for the Cpu data-port memory interface: FSM encoding,
// response record and the request legality check used by both sides.
package mem_if_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam int unsigned WORD_BYTES = 4;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } mem_resp_t;

    // True when a request must be refused: conflicting ops, misaligned,
    // below the base address, or past the last word of the array.
    function automatic logic req_error(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned aw,
        input logic        both
    );
        logic [31:0] offset;
        logic [31:0] widx;
        logic        range_err;
        offset = addr - base;
        widx   = offset >> 2;
        if (aw >= 32'd32) begin
            range_err = 1'b0;
        end else begin
            range_err = ((widx >> aw) != 32'd0);
        end
        return both | (addr[1:0] != 2'b00) | (addr < base) | range_err;
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM: write on we, read data registered every cycle
// (read-before-write on a same-address access).
module sp_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];

    // Array write and registered read port; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the Cpu data port: checks each request, inserts
// WAIT_CYCLES wait states, performs one array access and pulses mem_ready.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam logic       HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]            state_r;
    logic [1:0]            next_state_s;
    logic [3:0]            cnt_r;
    logic [ADDR_WIDTH-1:0] idx_r;
    logic [31:0]           wdata_r;
    logic                  is_write_r;
    mem_resp_t             resp_r;
    logic                  ready_r;

    logic                  req_valid_s;
    logic                  req_err_s;
    logic [31:0]           offset_s;
    logic [ADDR_WIDTH-1:0] idx_in_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic                  ram_we_s;
    logic [31:0]           ram_rdata_s;
    logic                  unused_bits_s;

    assign req_valid_s   = mem_read | mem_write;
    assign req_err_s     = req_error(mem_addr, BASE_ADDR, ADDR_WIDTH, mem_read & mem_write);
    assign offset_s      = mem_addr - BASE_ADDR;
    assign idx_in_s      = offset_s[ADDR_WIDTH+1:2];
    assign unused_bits_s = ^{offset_s[31:ADDR_WIDTH+2], offset_s[1:0]};

    // In IDLE the RAM is addressed from the live request so that the
    // registered read word is already valid by the ACCESS cycle, even with
    // no wait states.
    always_comb begin
        ram_addr_s = idx_r;
        if (state_r == S_IDLE) begin
            ram_addr_s = idx_in_s;
        end else begin
            ram_addr_s = idx_r;
        end
    end

    assign ram_we_s = (state_r == S_ACCESS) & is_write_r;

    sp_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(32)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we_s),
        .addr (ram_addr_s),
        .wdata(wdata_r),
        .rdata(ram_rdata_s)
    );

    // Next-state logic for the IDLE -> [WAIT] -> ACCESS -> RESP sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!req_valid_s) begin
                    next_state_s = S_IDLE;
                end else if (req_err_s) begin
                    next_state_s = S_RESP;
                end else if (HAS_WAIT) begin
                    next_state_s = S_WAIT;
                end else begin
                    next_state_s = S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = S_ACCESS;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_ACCESS: next_state_s = S_RESP;
            S_RESP:   next_state_s = S_IDLE;
            default:  next_state_s = S_IDLE;
        endcase
    end

    // State, wait counter and latched request; inputs are only sampled in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= 4'd0;
            idx_r      <= '0;
            wdata_r    <= 32'd0;
            is_write_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == S_IDLE) && req_valid_s) begin
                idx_r      <= idx_in_s;
                wdata_r    <= mem_wdata;
                is_write_r <= mem_write;
                cnt_r      <= WAIT_LOAD;
            end else if ((state_r == S_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // Output registers: loaded on entry to RESP, error cleared once the pulse
    // ends, read data held until the next completed transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_r      <= 1'b0;
            resp_r.err   <= 1'b0;
            resp_r.rdata <= 32'd0;
        end else begin
            ready_r <= (next_state_s == S_RESP);
            if ((state_r == S_IDLE) && req_valid_s && req_err_s) begin
                resp_r.err   <= 1'b1;
                resp_r.rdata <= 32'd0;
            end else if (state_r == S_ACCESS) begin
                resp_r.err   <= 1'b0;
                resp_r.rdata <= is_write_r ? 32'd0 : ram_rdata_s;
            end else if (state_r == S_RESP) begin
                resp_r.err <= 1'b0;
            end
        end
    end

    assign mem_ready = ready_r;
    assign mem_err   = resp_r.err;
    assign mem_rdata = resp_r.rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: dut_a has two wait states, dut_b none; drivers queue the
// expected response and cycle, monitors check every mem_ready pulse.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
    logic        a_read, a_write, a_ready, a_err;
    logic        b_read, b_write, b_ready, b_err;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut_a (
        .clk(clk), .rst(rst), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .mem_read(a_read), .mem_write(a_write), .mem_rdata(a_rdata),
        .mem_ready(a_ready), .mem_err(a_err)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_b (
        .clk(clk), .rst(rst), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_read(b_read), .mem_write(b_write), .mem_rdata(b_rdata),
        .mem_ready(b_ready), .mem_err(b_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (a_ready === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                ea = q_a.pop_front();
                check("a_err", {31'd0, a_err}, {31'd0, ea.err});
                check("a_rdata", a_rdata, ea.rdata);
                check("a_cycle", 32'(cyc), 32'(ea.due));
            end
        end
        if (b_ready === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                eb = q_b.pop_front();
                check("b_err", {31'd0, b_err}, {31'd0, eb.err});
                check("b_rdata", b_rdata, eb.rdata);
                check("b_cycle", 32'(cyc), 32'(eb.due));
            end
        end
    end

    task automatic drive(input bit sel_b, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel_b) begin
            b_read = rd; b_write = wr; b_addr = addr; b_wdata = wdata;
        end else begin
            a_read = rd; a_write = wr; a_addr = addr; a_wdata = wdata;
        end
    endtask

    task automatic push(input bit sel_b, input logic err, input logic [31:0] rdata, input int due);
        exp_t e;
        e.err = err; e.rdata = rdata; e.due = due;
        if (sel_b) q_b.push_back(e);
        else q_a.push_back(e);
    endtask

    // Returns at the negedge where mem_ready is seen, or after a bounded wait.
    task automatic wait_pulse(input bit sel_b);
        int   n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 30) begin
            @(negedge clk);
            n++;
            rdy = sel_b ? b_ready : a_ready;
        end
        check(sel_b ? "b_pulse_seen" : "a_pulse_seen", {31'd0, rdy}, 32'd1);
    endtask

    task automatic req(input bit sel_b, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata,
                       input int lat, input bit hold);
        @(negedge clk);
        drive(sel_b, rd, wr, addr, wdata);
        push(sel_b, exp_err, exp_rdata, cyc + lat);
        if (!hold) begin
            @(negedge clk);
            drive(sel_b, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        wait_pulse(sel_b);
        drive(sel_b, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("a_rst_ready", {31'd0, a_ready}, 32'd0);
        check("a_rst_err", {31'd0, a_err}, 32'd0);
        check("a_rst_rdata", a_rdata, 32'd0);
        check("b_rst_ready", {31'd0, b_ready}, 32'd0);
        check("b_rst_rdata", b_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // dut_a: WAIT_CYCLES=2, normal latency 4, error latency 1
        req(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 4, 1'b1);
        req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 4, 1'b1);
        req(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0, 4, 1'b1);
        req(1'b0, 1'b1, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0, 1, 1'b1);
        req(1'b0, 1'b0, 1'b1, 32'h12, 32'h99999999, 1'b1, 32'h0, 1, 1'b1);
        req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 4, 1'b1);
        req(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, 1, 1'b1);
        req(1'b0, 1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D, 1'b0, 32'h0, 4, 1'b1);
        req(1'b0, 1'b1, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'hCAFEF00D, 4, 1'b1);
        @(negedge clk);
        check("a_rdata_hold", a_rdata, 32'hCAFEF00D);
        req(1'b0, 1'b1, 1'b1, 32'h20, 32'hBAD0BAD0, 1'b1, 32'h0, 1, 1'b1);
        req(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678, 4, 1'b1);
        // request dropped after one cycle must still complete its write
        req(1'b0, 1'b0, 1'b1, 32'h30, 32'h00000077, 1'b0, 32'h0, 4, 1'b0);
        req(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h00000077, 4, 1'b1);

        // reset during WAIT aborts the write
        req(1'b0, 1'b0, 1'b1, 32'h8, 32'h11111111, 1'b0, 32'h0, 4, 1'b1);
        req(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h11111111, 4, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h8, 32'h00000055);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("a_abort_ready", {31'd0, a_ready}, 32'd0);
        check("a_abort_err", {31'd0, a_err}, 32'd0);
        check("a_abort_rdata", a_rdata, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h11111111, 4, 1'b1);

        // dut_b: WAIT_CYCLES=0, back-to-back reads held continuously
        req(1'b1, 1'b0, 1'b1, 32'h0, 32'hA0A0A0A0, 1'b0, 32'h0, 2, 1'b1);
        req(1'b1, 1'b0, 1'b1, 32'h4, 32'h0B0B0B0B, 1'b0, 32'h0, 2, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        push(1'b1, 1'b0, 32'hA0A0A0A0, cyc + 2);
        wait_pulse(1'b1);
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        push(1'b1, 1'b0, 32'h0B0B0B0B, cyc + 3);
        wait_pulse(1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        repeat (4) @(negedge clk);
        check("a_queue_empty", 32'(q_a.size()), 32'd0);
        check("b_queue_empty", 32'(q_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
